// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one sram-like uncached bus port between the instruction-fetch
// requester (I) and the memory-stage data requester (D).
// One transaction is in flight at a time. When both requesters ask in the
// same IDLE cycle, the one that did not win last time gets the bus.
// Ports:
//   Clk, Clr_n       clock, asynchronous active-low reset
//   inst_*           I side: read-only requests, addr_ok/data_ok/rdata back,
//                    inst_cancel drops a pending I response (pipeline flush)
//   data_*           D side: loads/stores with size/strobe/wdata,
//                    addr_ok/data_ok/rdata back
//   bus_*            shared bus port toward the bus bridge
module mem_port_arbiter (
    input  logic        Clk,
    input  logic        Clr_n,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        inst_cancel,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [1:0]  bus_size,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        drop_q, drop_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;

    logic        inst_part_s;
    logic        grant_s;

    // A fetch that is being flushed in the same cycle must not win the bus.
    assign inst_part_s = inst_req & ~inst_cancel;

    // Arbitration winner: a lone requester wins, a tie goes to the non-last owner.
    always_comb begin
        grant_s = OWN_I;
        if (inst_part_s && data_req) begin
            grant_s = ~last_owner_q;
        end else if (data_req) begin
            grant_s = OWN_D;
        end else begin
            grant_s = OWN_I;
        end
    end

    // State and latched request fields.
    always_ff @(posedge Clk or negedge Clr_n) begin
        if (!Clr_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            drop_q       <= 1'b0;
            wr_q         <= 1'b0;
            size_q       <= 2'd0;
            addr_q       <= 32'd0;
            wstrb_q      <= 4'd0;
            wdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            drop_q       <= drop_d;
            wr_q         <= wr_d;
            size_q       <= size_d;
            addr_q       <= addr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
        end
    end

    // Next state, grant latching and drop-flag tracking.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        drop_d       = drop_q;
        wr_d         = wr_q;
        size_d       = size_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        case (state_q)
            ST_IDLE: begin
                drop_d = 1'b0;
                if (inst_part_s || data_req) begin
                    state_d      = ST_REQ;
                    owner_d      = grant_s;
                    last_owner_d = grant_s;
                    if (grant_s == OWN_D) begin
                        wr_d    = data_wr;
                        size_d  = data_size;
                        addr_d  = data_addr;
                        wstrb_d = data_wstrb;
                        wdata_d = data_wdata;
                    end else begin
                        // Fetches are always full-word reads.
                        wr_d    = 1'b0;
                        size_d  = 2'd2;
                        addr_d  = inst_addr;
                        wstrb_d = 4'd0;
                        wdata_d = 32'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_addr_ok) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_REQ;
                end
                if (inst_cancel && (owner_q == OWN_I)) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end else if (inst_cancel && (owner_q == OWN_I)) begin
                    drop_d = 1'b1;
                end else begin
                    drop_d = drop_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                drop_d  = 1'b0;
            end
        endcase
    end

    // Bus drive and handshake routing back to the current owner only.
    always_comb begin
        bus_req      = 1'b0;
        bus_wr       = 1'b0;
        bus_size     = 2'd0;
        bus_addr     = 32'd0;
        bus_wstrb    = 4'd0;
        bus_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
        case (state_q)
            ST_REQ: begin
                bus_req      = 1'b1;
                bus_wr       = wr_q;
                bus_size     = size_q;
                bus_addr     = addr_q;
                bus_wstrb    = wstrb_q;
                bus_wdata    = wdata_q;
                inst_addr_ok = bus_addr_ok & (owner_q == OWN_I);
                data_addr_ok = bus_addr_ok & (owner_q == OWN_D);
            end
            ST_WAIT: begin
                // A cancel arriving with the response suppresses it too.
                inst_data_ok = bus_data_ok & (owner_q == OWN_I) & ~drop_q & ~inst_cancel;
                data_data_ok = bus_data_ok & (owner_q == OWN_D);
            end
            default: begin
                bus_req = 1'b0;
            end
        endcase
    end

endmodule
